// File: rtl/duck_hunt_pkg.sv
// duck_hunt_pkg: shared widths, limits, colours and hit-detect state encoding
package duck_hunt_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int N_BIRDS = 7;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
  localparam logic [2:0] COL_ERASE = 3'b000;
  typedef enum logic [2:0] {IDLE, ARMED, SCAN, REPORT, COOLDOWN} state_t;
endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down-counter stepped by the frame strobe
module frame_down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;
  // load wins over a strobe; the count parks at zero
  always_comb begin
    count_d = load ? load_val : (en && count_q != '0) ? count_q - W'(1) : count_q;
  end
  // count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
  assign zero = count_q == '0;
endmodule

// File: rtl/bird_hit_detect.sv
// bird_hit_detect: scores birds drawn inside the aim window over one frame after a shot
module bird_hit_detect import duck_hunt_pkg::*; #(
  parameter int N_BIRDS = duck_hunt_pkg::N_BIRDS,
  parameter int AIM_HALF = 2,
  parameter int HOLD_FRAMES = 15,
  parameter int X_MAX = duck_hunt_pkg::X_MAX,
  parameter int Y_MAX = duck_hunt_pkg::Y_MAX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               one_frame,
  input  logic               shoot,
  input  logic [X_W-1:0]     aim_x,
  input  logic [Y_W-1:0]     aim_y,
  input  logic               plot,
  input  logic [2:0]         colour,
  input  logic [X_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  input  logic [2:0]         pix_bird,
  output logic               busy,
  output logic               hit_valid,
  output logic [N_BIRDS-1:0] hit_mask,
  output logic [7:0]         score
);
  localparam int CW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES + 1) : 1;
  state_t state_q, state_d;
  logic shoot_q, fire, pix_hit, cnt_load, cnt_zero, hit_valid_q, hit_valid_d;
  logic [X_W-1:0] lo_x_q, lo_x_d, hi_x_q, hi_x_d;
  logic [Y_W-1:0] lo_y_q, lo_y_d, hi_y_q, hi_y_d;
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic [N_BIRDS-1:0] hit_acc_q, hit_acc_d, hit_mask_q, hit_mask_d, acc_next;
  logic [7:0] score_q, score_d, pc;
  logic [8:0] score_sum;
  logic [CW-1:0] cnt;
  assign fire = shoot & ~shoot_q;
  // clamped window bounds, pixel qualification and saturating score
  always_comb begin
    sum_x = {1'b0, aim_x} + (X_W+1)'(AIM_HALF);
    sum_y = {1'b0, aim_y} + (Y_W+1)'(AIM_HALF);
    lo_x_d = lo_x_q;
    hi_x_d = hi_x_q;
    lo_y_d = lo_y_q;
    hi_y_d = hi_y_q;
    pix_hit = plot && colour != COL_ERASE && pix_x >= lo_x_q && pix_x <= hi_x_q &&
              pix_y >= lo_y_q && pix_y <= hi_y_q && int'(pix_bird) < N_BIRDS;
    acc_next = hit_acc_q | (pix_hit ? N_BIRDS'(1) << pix_bird : '0);
    pc = '0;
    for (int i = 0; i < N_BIRDS; i++) pc = pc + 8'(acc_next[i]);
    score_sum = {1'b0, score_q} + {1'b0, pc};
    state_d = state_q;
    hit_acc_d = hit_acc_q;
    hit_mask_d = hit_mask_q;
    score_d = score_q;
    hit_valid_d = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: if (fire) begin
        lo_x_d = aim_x >= X_W'(AIM_HALF) ? aim_x - X_W'(AIM_HALF) : '0;
        lo_y_d = aim_y >= Y_W'(AIM_HALF) ? aim_y - Y_W'(AIM_HALF) : '0;
        hi_x_d = sum_x > (X_W+1)'(X_MAX) ? X_W'(X_MAX) : sum_x[X_W-1:0];
        hi_y_d = sum_y > (Y_W+1)'(Y_MAX) ? Y_W'(Y_MAX) : sum_y[Y_W-1:0];
        hit_acc_d = '0;
        state_d = ARMED;
      end
      ARMED: state_d = one_frame ? SCAN : ARMED;
      SCAN: begin
        hit_acc_d = acc_next;
        if (one_frame) begin
          state_d = REPORT;
          hit_valid_d = 1'b1;
          hit_mask_d = acc_next;
          score_d = score_sum > 9'd255 ? 8'hFF : score_sum[7:0];
        end
      end
      REPORT: begin
        cnt_load = 1'b1;
        state_d = COOLDOWN;
      end
      COOLDOWN: state_d = (cnt_zero || (one_frame && cnt == CW'(1))) ? IDLE : COOLDOWN;
      default: state_d = IDLE;
    endcase
  end
  // state, window, accumulator and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shoot_q <= 1'b0;
      lo_x_q <= '0;
      hi_x_q <= '0;
      lo_y_q <= '0;
      hi_y_q <= '0;
      hit_acc_q <= '0;
      hit_mask_q <= '0;
      score_q <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shoot_q <= shoot;
      lo_x_q <= lo_x_d;
      hi_x_q <= hi_x_d;
      lo_y_q <= lo_y_d;
      hi_y_q <= hi_y_d;
      hit_acc_q <= hit_acc_d;
      hit_mask_q <= hit_mask_d;
      score_q <= score_d;
      hit_valid_q <= hit_valid_d;
    end
  end
  frame_down_counter #(.W(CW)) u_cool (
    .clock(clock),
    .reset(reset),
    .en(one_frame),
    .load(cnt_load),
    .load_val(CW'(HOLD_FRAMES)),
    .count(cnt),
    .zero(cnt_zero)
  );
  assign busy = state_q != IDLE;
  assign hit_valid = hit_valid_q;
  assign hit_mask = hit_mask_q;
  assign score = score_q;
endmodule

// File: tb/tb_bird_hit_detect.sv
// tb_bird_hit_detect: scoreboard bench for bird_hit_detect
module tb_bird_hit_detect;
  localparam int HOLD = 15;
  logic clock = 0, reset = 1, one_frame = 0, shoot = 0, plot = 0;
  logic [7:0] aim_x = 0, pix_x = 0;
  logic [6:0] aim_y = 0, pix_y = 0;
  logic [2:0] colour = 0, pix_bird = 0;
  logic busy, hit_valid;
  logic [6:0] hit_mask;
  logic [7:0] score;
  int n_cmp = 0, n_bad = 0;
  logic [14:0] sb[$];
  logic [14:0] mon_e;
  logic [6:0] exp_acc = 0;
  int exp_score = 0, mst = 0, lx, hx, ly, hy, k;

  bird_hit_detect dut (
    .clock(clock), .reset(reset), .one_frame(one_frame), .shoot(shoot),
    .aim_x(aim_x), .aim_y(aim_y), .plot(plot), .colour(colour),
    .pix_x(pix_x), .pix_y(pix_y), .pix_bird(pix_bird),
    .busy(busy), .hit_valid(hit_valid), .hit_mask(hit_mask), .score(score)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit pl, input int x, input int y, input int c, input int b, input bit fr);
    plot = pl; pix_x = 8'(x); pix_y = 7'(y); colour = 3'(c); pix_bird = 3'(b); one_frame = fr;
    if (pl && mst == 2 && c != 0 && x >= lx && x <= hx && y >= ly && y <= hy && b < 7) exp_acc[b] = 1'b1;
    if (fr && mst == 2) begin
      exp_score = exp_score + $countones(exp_acc);
      if (exp_score > 255) exp_score = 255;
      sb.push_back({exp_acc, 8'(exp_score)});
      mst = 3;
    end else if (fr && mst == 1) mst = 2;
    tick();
    plot = 0; one_frame = 0;
  endtask

  task automatic frame();
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic shot(input int ax, input int ay);
    aim_x = 8'(ax); aim_y = 7'(ay);
    lx = ax < 2 ? 0 : ax - 2; hx = ax + 2 > 159 ? 159 : ax + 2;
    ly = ay < 2 ? 0 : ay - 2; hy = ay + 2 > 119 ? 119 : ay + 2;
    shoot = 1;
    tick();
    shoot = 0;
    check("busy_after_shot", busy, 1);
    exp_acc = 0; mst = 1;
    tick();
  endtask

  task automatic arm();
    drive(1, aim_x, aim_y, 7, 4, 1);
    tick();
  endtask

  task automatic finish_report();
    check("hit_valid_report", hit_valid, 1);
    tick();
    check("hit_valid_drop", hit_valid, 0);
    check("report_pending", sb.size(), 0);
    for (int i = 0; i < HOLD; i++) begin
      check("cool_busy", busy, 1);
      if (i == 3) begin
        shoot = 1; tick(); shoot = 0;
      end
      tick(); tick();
      frame();
    end
    check("cool_idle", busy, 0);
    mst = 0;
  endtask

  initial forever begin
    @(posedge clock);
    #2;
    if (hit_valid) begin
      if (sb.size() == 0) check("unexpected_report", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("mask", hit_mask, mon_e[14:8]);
        check("score", score, mon_e[7:0]);
      end
    end
  end

  initial begin
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", hit_valid, 0);
    check("rst_mask", hit_mask, 0);
    check("rst_score", score, 0);
    reset = 0;
    tick(); tick();
    shot(80, 60); arm();
    shoot = 1; tick(); shoot = 0;
    drive(1, 81, 59, 7, 2, 0);
    drive(1, 81, 59, 7, 7, 0);
    tick();
    frame();
    check("direct_mask", hit_mask, 7'b0000100);
    check("direct_score", score, 1);
    finish_report();
    shot(80, 60); arm();
    drive(1, 80, 60, 0, 0, 0);
    drive(1, 83, 60, 7, 1, 0);
    frame();
    check("miss_mask", hit_mask, 0);
    check("miss_score", score, 1);
    finish_report();
    shot(0, 0); arm();
    drive(1, 159, 119, 7, 5, 0);
    drive(1, 0, 0, 7, 6, 1);
    check("edge_mask", hit_mask, 7'b1000000);
    check("edge_score", score, 2);
    finish_report();
    shot(80, 60); arm();
    drive(1, 80, 60, 7, 3, 0);
    #3 reset = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", hit_valid, 0);
    check("arst_mask", hit_mask, 0);
    check("arst_score", score, 0);
    tick();
    reset = 0; exp_score = 0; mst = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); frame();
    end
    check("post_rst_idle", busy, 0);
    while (exp_score < 254) begin
      k = 254 - exp_score < 7 ? 254 - exp_score : 7;
      shot(80, 60); arm();
      for (int b = 0; b < k; b++) drive(1, 80, 60, 7, b, 0);
      frame();
      finish_report();
    end
    check("preload_score", score, 254);
    shot(80, 60); arm();
    drive(1, 79, 61, 7, 0, 0);
    drive(1, 80, 60, 7, 0, 0);
    drive(1, 82, 62, 7, 0, 0);
    drive(1, 78, 58, 7, 1, 0);
    drive(1, 80, 60, 7, 3, 0);
    frame();
    check("multi_mask", hit_mask, 7'b0001011);
    check("sat_score", score, 255);
    finish_report();
    tick(); tick();
    check("end_pending", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bird_hit_detect.md
# bird_hit_detect

Reader at the far end of the bird pixel-write stream. It watches the same `plot`/`pix_x`/`pix_y`/`colour` writes the draw controller sends to the VGA adapter, plus a bird index. When the player fires, it decides which birds had a drawn pixel inside the aim window during one full frame. It reports a per-bird hit mask and keeps a running score. It sits beside the VGA adapter and feeds the game-control logic.

## Interface
Parameters:
- `N_BIRDS`, 7: number of bird slots; width of `hit_mask`.
- `AIM_HALF`, 2: half-size of the square aim window, in pixels.
- `HOLD_FRAMES`, 15: cooldown length in frames after each report.
- `X_MAX`, 159: largest legal x coordinate.
- `Y_MAX`, 119: largest legal y coordinate.

Ports:
- `clock`, in, 1: system clock (CLOCK_50 domain). One clock; reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `one_frame`, in, 1: single-cycle strobe, once per frame.
- `shoot`, in, 1: fire request, level; an edge detector is inside the block.
- `aim_x`, in, 8: crosshair x.
- `aim_y`, in, 7: crosshair y.
- `plot`, in, 1: a pixel write is valid this cycle.
- `colour`, in, 3: colour of the pixel write; 000 is an erase.
- `pix_x`, in, 8: pixel write x.
- `pix_y`, in, 7: pixel write y.
- `pix_bird`, in, 3: index of the bird being drawn.
- `busy`, out, 1: high in every state except IDLE.
- `hit_valid`, out, 1: single-cycle report strobe.
- `hit_mask`, out, N_BIRDS: birds hit; held until the next report.
- `score`, out, 8: running hit count; saturates at 255.

## Operation
- **Fire edge.** `shoot_q` is registered each cycle. A rising edge is `shoot & ~shoot_q`. A rising edge is acted on only in IDLE; in any other state it is discarded, not queued.
- **Window latch.** On acceptance, the window is latched:
  - `lo_x = max(aim_x - AIM_HALF, 0)` and `hi_x = min(aim_x + AIM_HALF, X_MAX)`.
  - y bounds are computed the same way against `Y_MAX`.
  - Arithmetic is done 1 bit wider and clamped, so there is no wrap-around.
- **States:**
  - **IDLE**: on an accepted rising edge, latch the window, clear `hit_acc`, go to ARMED.
  - **ARMED**: wait for `one_frame`, then go to SCAN. This aligns the scan to a frame boundary.
  - **SCAN**: a pixel sets `hit_acc[pix_bird]` when all of these hold in the same cycle:
    - `plot` = 1;
    - `colour` != 000;
    - `lo_x <= pix_x <= hi_x`;
    - `lo_y <= pix_y <= hi_y`;
    - `pix_bird < N_BIRDS`.
    
    Erase writes and out-of-range bird indices are ignored. The next `one_frame` moves to REPORT.
  - **REPORT**: for one cycle:
    - `hit_valid` = 1;
    - `hit_mask <= hit_acc`;
    - `score <= min(score + popcount(hit_acc), 255)`.
    
    Then go to COOLDOWN and load the frame counter with `HOLD_FRAMES`.
  - **COOLDOWN**: each `one_frame` decrements the counter. When the counter reaches 0 on a strobe, go to IDLE. With `HOLD_FRAMES` = 0, return to IDLE on the next cycle.
- **Simultaneous events:**
  - In SCAN, if a qualifying pixel and `one_frame` arrive in the same cycle, the pixel is counted in the closing frame.
  - In ARMED, a pixel arriving in the same cycle as `one_frame` is not counted.
- **Repeated hits.** Several hits on the same bird within one frame count once.
- **Reset:** asserting reset at any point, mid-scan included, forces IDLE:
  - `hit_acc`, `hit_mask`, `score`, the counter and `shoot_q` all go to 0;
  - `hit_valid` and `busy` go to 0.

## Timing
- All outputs are registered.
- Reset values: `busy` = 0, `hit_valid` = 0, `hit_mask` = 0, `score` = 0.
- `shoot` rises in cycle t (in IDLE): state is ARMED and `busy` = 1 in cycle t+1.
- The closing `one_frame` of SCAN is sampled in cycle t: in cycle t+1, `hit_valid` = 1 and `hit_mask`/`score` are updated. In cycle t+2, `hit_valid` = 0 and the state is COOLDOWN.
- Latency from shot acceptance to report: 1 to 2 frames plus 2 cycles.
- Minimum interval between reports: 1 + 1 + `HOLD_FRAMES` frames.

## Structure
- **Shared package** (`duck_hunt_pkg`):
  - coordinate widths (X_W = 8, Y_W = 7);
  - `N_BIRDS`;
  - `X_MAX`/`Y_MAX`;
  - the erase colour constant 3'b000;
  - the state encoding for IDLE, ARMED, SCAN, REPORT and COOLDOWN.
- **Sub-module** `frame_down_counter`:
  - loadable down-counter clocked by `clock` and enabled by `one_frame`, with a `zero` flag;
  - used for COOLDOWN and reusable for game timers.
- Comparator and popcount stay inline.

## Test plan
- **Direct hit.** Aim (80,60); shoot; in SCAN, write a pixel at (81,59), colour 111, bird 2 → one cycle after the closing `one_frame`: `hit_valid` = 1, `hit_mask` = 0000100, `score` = 1.
- **Erase and miss.** Aim (80,60); in SCAN, write an erase at (80,60) for bird 0, and a colour-111 pixel at (83,60) for bird 1 → `hit_mask` = 0, `score` unchanged.
- **Edge clamping.** Aim (0,0); write colour-111 pixels at (0,0) for bird 6 and at (159,119) for bird 5 → `hit_mask` = 1000000, confirming no wrap.
- **Multi-hit and saturation.** Preload `score` = 254; hit birds 0, 1 and 3, with bird 0 hit three times → `hit_mask` = 0001011, `score` = 255.
- **Ignored shots and cooldown.** Pulse `shoot` during SCAN and during COOLDOWN → no extra report. `busy` falls exactly `HOLD_FRAMES` frame strobes after the report; the next shot is then accepted.
- **Reset mid-operation.** Assert reset in SCAN after a qualifying hit → all outputs go to 0 asynchronously; no `hit_valid` follows; the state is IDLE.
